// File: rtl/store_queue_pkg.sv
// Shared memory-stage types: sequence numbers, the mispredict bus layout,
// store entries and the wrap-safe age compare also used by the load buffer.
package store_queue_pkg;

  localparam int SQN_W              = 6;
  localparam int SQ_DEFAULT_ENTRIES = 8;

  typedef logic [SQN_W-1:0] SqN;

  // 52-bit mispredict bus, MSB first.
  typedef struct packed {
    logic        valid;
    logic [31:0] dst;
    SqN          sqN;
    SqN          storeSqN;
    SqN          loadSqN;
    logic        flush;
  } BranchProv;

  typedef struct packed {
    SqN          sqN;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
  } StorePayload;

  typedef struct packed {
    logic        valid;
    logic        committed;
    StorePayload p;
  } StoreEntry;

  // x is younger than y when the 6-bit wrapped difference is positive.
  function automatic logic is_younger(input SqN x, input SqN y);
    SqN diff;
    diff = x - y;
    return $signed(diff) > 0;
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Data-memory write port between the store queue (master) and memory (slave).
interface store_queue_if;

  // Handshake: a request transfers on a clock edge where OUT_memValid and
  // IN_memReady are both high. Once OUT_memValid rises, the address, data and
  // mask hold stable until that transfer; IN_memReady may change freely and
  // the master never withdraws a pending request.
  logic        OUT_memValid;
  logic [29:0] OUT_memAddr;
  logic [31:0] OUT_memData;
  logic [3:0]  OUT_memMask;
  logic        IN_memReady;

  modport master (
    output OUT_memValid,
    output OUT_memAddr,
    output OUT_memData,
    output OUT_memMask,
    input  IN_memReady
  );

  modport slave (
    input  OUT_memValid,
    input  OUT_memAddr,
    input  OUT_memData,
    input  OUT_memMask,
    output IN_memReady
  );

endinterface

// File: rtl/store_queue.sv
// Store queue: buffers executed stores until commit, drops squashed ones on
// mispredict, and retires committed stores in order to the memory write port.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = SQ_DEFAULT_ENTRIES
) (
  input  logic                clk,
  input  logic                rst,
  input  SqN                  IN_commitSqN,
  input  logic                IN_valid,
  input  SqN                  IN_sqN,
  input  SqN                  IN_storeSqN,
  input  logic [31:0]         IN_addr,
  input  logic [31:0]         IN_data,
  input  logic [3:0]          IN_wmask,
  input  BranchProv           IN_branch,
  output SqN                  OUT_maxStoreSqN,
  store_queue_if.master       mem,
  output logic                OUT_empty
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] committed_q, committed_d;
  logic [NUM_ENTRIES-1:0] commit_now, squash_now;
  StorePayload            payload_q [NUM_ENTRIES];

  SqN               base_index_q, base_index_d;
  SqN               max_sqn_q;
  logic [IDX_W-1:0] head_idx, enq_idx;
  StoreEntry        head;
  logic             enq_ok;
  logic             drain_fire;

  // Slots are addressed by the low bits of storeSqN, so the head slot is the
  // low bits of baseIndex and allocation order equals ring order.
  assign head_idx = base_index_q[IDX_W-1:0];
  assign enq_idx  = IN_storeSqN[IDX_W-1:0];

  // A store arriving alongside a mispredict that squashes it is dropped.
  assign enq_ok = IN_valid && !(IN_branch.valid && is_younger(IN_sqN, IN_branch.sqN));

  assign head = '{valid: valid_q[head_idx], committed: committed_q[head_idx],
                  p: payload_q[head_idx]};

  assign mem.OUT_memValid = head.valid && head.committed;
  assign mem.OUT_memAddr  = head.p.addr;
  assign mem.OUT_memData  = head.p.data;
  assign mem.OUT_memMask  = head.p.wmask;

  assign drain_fire   = mem.OUT_memValid && mem.IN_memReady;
  assign base_index_d = base_index_q + SqN'(drain_fire);

  // Commit and squash both look at pre-cycle state; a store that commits this
  // cycle is exempt from the squash.
  always_comb begin
    commit_now = '0;
    squash_now = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && !committed_q[i]) begin
        if (is_younger(IN_commitSqN, payload_q[i].sqN)) begin
          commit_now[i] = 1'b1;
        end else if (IN_branch.valid && is_younger(payload_q[i].sqN, IN_branch.sqN)) begin
          squash_now[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d     = valid_q & ~squash_now;
    committed_d = committed_q | commit_now;
    if (drain_fire) begin
      valid_d[head_idx]     = 1'b0;
      committed_d[head_idx] = 1'b0;
    end
    if (enq_ok) begin
      valid_d[enq_idx]     = 1'b1;
      committed_d[enq_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      committed_q  <= '0;
      base_index_q <= '0;
      max_sqn_q    <= SqN'(NUM_ENTRIES - 1);
    end else begin
      valid_q      <= valid_d;
      committed_q  <= committed_d;
      base_index_q <= base_index_d;
      max_sqn_q    <= base_index_d + SqN'(NUM_ENTRIES - 1);
    end
  end

  // Payload needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      payload_q[enq_idx] <= '{sqN: IN_sqN, addr: IN_addr[31:2], data: IN_data, wmask: IN_wmask};
    end
  end

  assign OUT_maxStoreSqN = max_sqn_q;
  assign OUT_empty       = ~|valid_q;

  logic unused_sigs;
  assign unused_sigs = ^{IN_addr[1:0], IN_branch.dst, IN_branch.storeSqN, IN_branch.loadSqN,
                         IN_branch.flush, IN_storeSqN[SQN_W-1:IDX_W], head.p.sqN};

  enq_into_free_slot: assert property (@(posedge clk) disable iff (rst)
    enq_ok |-> !valid_q[enq_idx]);

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: drain, backpressure, mispredict, wrap, async reset.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  SqN          commit_sqn, in_sqn, in_store_sqn, max_sqn;
  logic        in_valid;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_wmask;
  logic [51:0] in_branch;
  logic        empty;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [65:0] exp_q[$];

  store_queue_if mem_if();

  store_queue #(.NUM_ENTRIES(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_commitSqN   (commit_sqn),
    .IN_valid       (in_valid),
    .IN_sqN         (in_sqn),
    .IN_storeSqN    (in_store_sqn),
    .IN_addr        (in_addr),
    .IN_data        (in_data),
    .IN_wmask       (in_wmask),
    .IN_branch      (in_branch),
    .OUT_maxStoreSqN(max_sqn),
    .mem            (mem_if),
    .OUT_empty      (empty)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_sqn       = '0;
    in_store_sqn = '0;
    in_addr      = '0;
    in_data      = '0;
    in_wmask     = '0;
    in_branch    = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    commit_sqn         = '0;
    mem_if.IN_memReady = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_store(input SqN ssq, input SqN sq, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m);
    in_valid     = 1'b1;
    in_store_sqn = ssq;
    in_sqn       = sq;
    in_addr      = a;
    in_data      = d;
    in_wmask     = m;
  endtask

  function automatic logic [51:0] mk_branch(input logic v, input SqN sq);
    return {v, 32'h0000_4000, sq, 6'd0, 6'd0, 1'b0};
  endfunction

  // Scenarios
  task automatic test_reset();
    apply_reset();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL reset_memvalid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd7) begin err_cnt++; $display("FAIL reset_maxsqn: got %0d want 7", max_sqn); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b want 1", empty); end
  endtask

  task automatic test_basic_drain();
    apply_reset();
    commit_sqn = 6'd6;
    mem_if.IN_memReady = 1'b1;
    drive_store(6'd0, 6'd5, 32'h100, 32'hDEAD_BEEF, 4'hF);
    step();
    idle_inputs();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL basic_early_valid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("FAIL basic_not_empty: got %b want 0", empty); end
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %b want 1", mem_if.OUT_memValid); end
    cmp_cnt++; if (mem_if.OUT_memAddr !== 30'h40) begin err_cnt++; $display("FAIL basic_addr: got %h want 40", mem_if.OUT_memAddr); end
    cmp_cnt++; if (mem_if.OUT_memData !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL basic_data: got %h want deadbeef", mem_if.OUT_memData); end
    cmp_cnt++; if (mem_if.OUT_memMask !== 4'hF) begin err_cnt++; $display("FAIL basic_mask: got %h want f", mem_if.OUT_memMask); end
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL basic_after_valid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd8) begin err_cnt++; $display("FAIL basic_maxsqn: got %0d want 8", max_sqn); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL basic_empty: got %b want 1", empty); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    commit_sqn = 6'd6;
    drive_store(6'd0, 6'd5, 32'h200, 32'h1234_5678, 4'h3);
    step();
    idle_inputs();
    step();
    for (int c = 0; c < 5; c++) begin
      cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid[%0d]: got %b want 1", c, mem_if.OUT_memValid); end
      cmp_cnt++; if (mem_if.OUT_memAddr !== 30'h80) begin err_cnt++; $display("FAIL bp_addr[%0d]: got %h want 80", c, mem_if.OUT_memAddr); end
      cmp_cnt++; if (mem_if.OUT_memData !== 32'h1234_5678) begin err_cnt++; $display("FAIL bp_data[%0d]: got %h want 12345678", c, mem_if.OUT_memData); end
      cmp_cnt++; if (mem_if.OUT_memMask !== 4'h3) begin err_cnt++; $display("FAIL bp_mask[%0d]: got %h want 3", c, mem_if.OUT_memMask); end
      cmp_cnt++; if (max_sqn !== 6'd7) begin err_cnt++; $display("FAIL bp_maxsqn[%0d]: got %0d want 7", c, max_sqn); end
      if (c < 4) step();
    end
    mem_if.IN_memReady = 1'b1;
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL bp_released_valid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd8) begin err_cnt++; $display("FAIL bp_released_maxsqn: got %0d want 8", max_sqn); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL bp_released_empty: got %b want 1", empty); end
    step();
    cmp_cnt++; if (max_sqn !== 6'd8) begin err_cnt++; $display("FAIL bp_single_transfer: got %0d want 8", max_sqn); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    commit_sqn = 6'd9;
    for (int i = 0; i < 4; i++) begin
      drive_store(SqN'(i), SqN'(10 + 2 * i), 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      step();
    end
    idle_inputs();
    commit_sqn = 6'd11;
    in_branch  = mk_branch(1'b1, 6'd13);
    step();
    in_branch  = '0;
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL mp_head_valid: got %b want 1", mem_if.OUT_memValid); end
    cmp_cnt++; if (mem_if.OUT_memAddr !== 30'h400) begin err_cnt++; $display("FAIL mp_head_addr: got %h want 400", mem_if.OUT_memAddr); end
    mem_if.IN_memReady = 1'b1;
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL mp_uncommitted_held: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd8) begin err_cnt++; $display("FAIL mp_maxsqn_1: got %0d want 8", max_sqn); end
    cmp_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("FAIL mp_not_empty: got %b want 0", empty); end
    commit_sqn = 6'd13;
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL mp_second_valid: got %b want 1", mem_if.OUT_memValid); end
    cmp_cnt++; if (mem_if.OUT_memAddr !== 30'h401) begin err_cnt++; $display("FAIL mp_second_addr: got %h want 401", mem_if.OUT_memAddr); end
    cmp_cnt++; if (mem_if.OUT_memData !== 32'hA1) begin err_cnt++; $display("FAIL mp_second_data: got %h want a1", mem_if.OUT_memData); end
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL mp_final_valid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd9) begin err_cnt++; $display("FAIL mp_maxsqn_2: got %0d want 9", max_sqn); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL mp_squashed_empty: got %b want 1", empty); end
  endtask

  task automatic test_enq_mispredict();
    apply_reset();
    in_branch = mk_branch(1'b1, 6'd18);
    drive_store(6'd0, 6'd20, 32'h300, 32'h55, 4'hF);
    step();
    idle_inputs();
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL enqmp_discard: got empty=%b want 1", empty); end
    in_branch = mk_branch(1'b1, 6'd18);
    drive_store(6'd0, 6'd17, 32'h304, 32'h66, 4'h1);
    step();
    idle_inputs();
    cmp_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("FAIL enqmp_accept: got empty=%b want 0", empty); end
    commit_sqn = 6'd18;
    mem_if.IN_memReady = 1'b1;
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL enqmp_valid: got %b want 1", mem_if.OUT_memValid); end
    cmp_cnt++; if (mem_if.OUT_memAddr !== 30'hC1) begin err_cnt++; $display("FAIL enqmp_addr: got %h want c1", mem_if.OUT_memAddr); end
    cmp_cnt++; if (mem_if.OUT_memData !== 32'h66) begin err_cnt++; $display("FAIL enqmp_data: got %h want 66", mem_if.OUT_memData); end
    cmp_cnt++; if (mem_if.OUT_memMask !== 4'h1) begin err_cnt++; $display("FAIL enqmp_mask: got %h want 1", mem_if.OUT_memMask); end
    step();
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL enqmp_drained: got %b want 1", empty); end
    cmp_cnt++; if (max_sqn !== 6'd8) begin err_cnt++; $display("FAIL enqmp_maxsqn: got %0d want 8", max_sqn); end
  endtask

  task automatic test_wrap();
    int          n_enq;
    int          n_drn;
    SqN          base_m;
    logic        can_enq;
    logic [31:0] a;
    logic [65:0] got;
    logic [65:0] want;
    apply_reset();
    exp_q.delete();
    n_enq  = 0;
    n_drn  = 0;
    base_m = '0;
    commit_sqn = 6'd40;
    for (int c = 0; c < 600 && n_drn < 70; c++) begin
      mem_if.IN_memReady = ((c % 5) != 2);
      cmp_cnt++; if (max_sqn !== base_m + 6'd7) begin err_cnt++; $display("FAIL wrap_maxsqn[c%0d]: got %0d want %0d", c, max_sqn, base_m + 6'd7); end
      can_enq = (n_enq < 70) && ((c % 4) != 0) && ((SqN'(n_enq) - base_m) < SqN'(N));
      if (mem_if.OUT_memValid && mem_if.IN_memReady) begin
        got = {mem_if.OUT_memAddr, mem_if.OUT_memData, mem_if.OUT_memMask};
        if (exp_q.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL wrap_unexpected_write: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          cmp_cnt++; if (got !== want) begin err_cnt++; $display("FAIL wrap_write[%0d]: got %h want %h", n_drn, got, want); end
        end
        n_drn++;
        base_m = base_m + 6'd1;
      end
      if (can_enq) begin
        a = 32'h8000 + 32'(4 * n_enq);
        drive_store(SqN'(n_enq), SqN'(40 + n_enq), a, 32'hC0DE_0000 + 32'(n_enq), 4'(n_enq % 16));
        exp_q.push_back({a[31:2], 32'hC0DE_0000 + 32'(n_enq), 4'(n_enq % 16)});
        n_enq++;
      end else begin
        in_valid = 1'b0;
      end
      commit_sqn = SqN'(40 + n_enq);
      step();
    end
    idle_inputs();
    cmp_cnt++; if (n_drn !== 70) begin err_cnt++; $display("FAIL wrap_drain_count: got %0d want 70", n_drn); end
    cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL wrap_empty: got %b want 1", empty); end
    cmp_cnt++; if (max_sqn !== 6'd13) begin err_cnt++; $display("FAIL wrap_final_maxsqn: got %0d want 13", max_sqn); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    commit_sqn = 6'd6;
    drive_store(6'd0, 6'd5, 32'h400, 32'hCAFE_F00D, 4'hF);
    step();
    idle_inputs();
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b1) begin err_cnt++; $display("FAIL ar_pre_valid: got %b want 1", mem_if.OUT_memValid); end
    #2;
    rst = 1'b1;
    #1;
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL ar_memvalid: got %b want 0", mem_if.OUT_memValid); end
    cmp_cnt++; if (max_sqn !== 6'd7) begin err_cnt++; $display("FAIL ar_maxsqn: got %0d want 7", max_sqn); end
    cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL ar_empty: got %b want 1", empty); end
    step();
    rst = 1'b0;
    step();
    cmp_cnt++; if (mem_if.OUT_memValid !== 1'b0) begin err_cnt++; $display("FAIL ar_post_valid: got %b want 0", mem_if.OUT_memValid); end
  endtask

  // Sequence and final report
  initial begin
    rst = 1'b1;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_mispredict();
    test_enq_mispredict();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
